// File: rtl/seg7_scan_reader.sv
// -----------------------------------------------------------------------------
// seg7_scan_reader
//
// Receive end of a time-multiplexed 7-segment display bus. The segment lines
// and one-hot digit selects are synchronised, a pattern is accepted once it
// has been stable for STABLE_CYC synchronised cycles, and the glyph is
// inverse-decoded back to a hex nibble for the selected digit. A one-cycle
// FRAME pulse marks the point where every digit has been captured at least
// once since the previous FRAME.
//
// Ports:
//   CLK       system clock
//   RST       asynchronous, active-high reset
//   SEGIN     segment lines a..g,dp in bits 7..0 (asynchronous to CLK)
//   DIGSEL    one-hot digit select, bit i = digit i (asynchronous to CLK)
//   HEXOUT    decoded digits, digit i in [4i+3:4i]
//   DPOUT     captured decimal point per digit
//   DIGERR    1 = last capture of digit i was not a valid hex glyph
//   FRAME     one-cycle pulse when all digits have been captured
//   FRAMEERR  qualified by FRAME: some capture in that frame was invalid
// -----------------------------------------------------------------------------
module seg7_scan_reader #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            SEGIN,
    input  logic [DIGITS-1:0]     DIGSEL,
    output logic [4*DIGITS-1:0]   HEXOUT,
    output logic [DIGITS-1:0]     DPOUT,
    output logic [DIGITS-1:0]     DIGERR,
    output logic                  FRAME,
    output logic                  FRAMEERR
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC);

    // Two-flop synchronisers for the asynchronous display bus.
    logic [7:0]          seg_s1_q, seg_s2_q;
    logic [DIGITS-1:0]   dig_s1_q, dig_s2_q;

    // Pattern the stability counter refers to (previous cycle's {D,S}).
    logic [7:0]          pat_seg_q;
    logic [DIGITS-1:0]   pat_dig_q;

    logic [7:0]          cnt_q, cnt_d;
    logic                sat_q;

    logic [4*DIGITS-1:0] hex_q, hex_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic                acc_q, acc_d;
    logic                frame_q, frame_d;
    logic                frame_err_q, frame_err_d;

    logic                pat_same;
    logic                capture;
    logic                frame_due;
    logic [4:0]          glyph;      // {valid, value}

    // Inverse of the DEC7SEG encoding; dp is ignored, so the table is
    // written with the dp bit forced to 0.
    function automatic logic [4:0] decode_glyph(input logic [6:0] segs);
        logic [4:0] res;
        case ({segs, 1'b0})
            8'hFC:   res = {1'b1, 4'h0};
            8'h60:   res = {1'b1, 4'h1};
            8'hDA:   res = {1'b1, 4'h2};
            8'hF2:   res = {1'b1, 4'h3};
            8'h66:   res = {1'b1, 4'h4};
            8'hB6:   res = {1'b1, 4'h5};
            8'hBE:   res = {1'b1, 4'h6};
            8'hE0:   res = {1'b1, 4'h7};
            8'hFE:   res = {1'b1, 4'h8};
            8'hF6:   res = {1'b1, 4'h9};
            8'hEE:   res = {1'b1, 4'hA};
            8'h3E:   res = {1'b1, 4'hB};
            8'h1A:   res = {1'b1, 4'hC};
            8'h7A:   res = {1'b1, 4'hD};
            8'h9E:   res = {1'b1, 4'hE};
            8'h8E:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    assign pat_same  = (seg_s2_q == pat_seg_q) && (dig_s2_q == pat_dig_q);
    assign cnt_d     = !pat_same         ? 8'd1 :
                       (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;

    // cnt_q counts how long pat_q has been stable. Capture fires only in the
    // first cycle the count sits at CNT_MAX (sat_q remembers the previous
    // cycle), so a held pattern is captured exactly once.
    assign capture   = (cnt_q == CNT_MAX) && !sat_q && $onehot(pat_dig_q);
    assign glyph     = decode_glyph(pat_seg_q[7:1]);
    assign frame_due = &seen_q;

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves a variable unassigned, which would infer a latch.
        hex_d       = hex_q;
        dp_d        = dp_q;
        err_d       = err_q;
        seen_d      = frame_due ? '0 : seen_q;
        acc_d       = frame_due ? 1'b0 : acc_q;
        frame_d     = frame_due;
        frame_err_d = frame_due ? acc_q : 1'b0;

        // A capture in the same edge that emits FRAME starts the new frame,
        // hence it is merged on top of the cleared mask/accumulator.
        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (pat_dig_q[i]) begin
                    dp_d[i]  = pat_seg_q[0];
                    err_d[i] = !glyph[4];
                    if (glyph[4]) begin
                        hex_d[4*i +: 4] = glyph[3:0];
                    end
                end
            end
            seen_d = seen_d | pat_dig_q;
            if (!glyph[4]) begin
                acc_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_s1_q    <= '0;
            seg_s2_q    <= '0;
            dig_s1_q    <= '0;
            dig_s2_q    <= '0;
            pat_seg_q   <= '0;
            pat_dig_q   <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            hex_q       <= '0;
            dp_q        <= '0;
            err_q       <= '0;
            seen_q      <= '0;
            acc_q       <= 1'b0;
            frame_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            seg_s1_q    <= SEGIN;
            seg_s2_q    <= seg_s1_q;
            dig_s1_q    <= DIGSEL;
            dig_s2_q    <= dig_s1_q;
            pat_seg_q   <= seg_s2_q;
            pat_dig_q   <= dig_s2_q;
            cnt_q       <= cnt_d;
            sat_q       <= (cnt_q == CNT_MAX);
            hex_q       <= hex_d;
            dp_q        <= dp_d;
            err_q       <= err_d;
            seen_q      <= seen_d;
            acc_q       <= acc_d;
            frame_q     <= frame_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign HEXOUT   = hex_q;
    assign DPOUT    = dp_q;
    assign DIGERR   = err_q;
    assign FRAME    = frame_q;
    assign FRAMEERR = frame_err_q;

endmodule
